// File: rtl/cmp_word_seq_pkg.sv
// Shared definitions for the wide-operand sequential magnitude comparator:
// state encodings, word width and the {great,equal,less} one-hot result codes.
package cmp_word_seq_pkg;

  localparam int CMP_WORD_W = 16;

  typedef enum logic [1:0] {
    CMP_S_IDLE = 2'd0,
    CMP_S_CMP  = 2'd1,
    CMP_S_DONE = 2'd2
  } cmp_state_e;

  // Result vector is ordered {great, equal, less}
  localparam logic [2:0] CMP_RES_NONE  = 3'b000;
  localparam logic [2:0] CMP_RES_GREAT = 3'b100;
  localparam logic [2:0] CMP_RES_EQUAL = 3'b010;
  localparam logic [2:0] CMP_RES_LESS  = 3'b001;

  function automatic logic [2:0] cmp_res_f(input logic gt, input logic lt);
    logic [2:0] res_s;
    if (gt) begin
      res_s = CMP_RES_GREAT;
    end else if (lt) begin
      res_s = CMP_RES_LESS;
    end else begin
      res_s = CMP_RES_EQUAL;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/cmp_word_seq_if.sv
// Operand/result handshake bundle for cmp_word_seq; the master side supplies
// operands and accepts results, the slave side is the comparator controller.
interface cmp_word_seq_if
  import cmp_word_seq_pkg::*;
#(
  parameter int WORDS = 4
);
  localparam int CW = $clog2(WORDS + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic [CMP_WORD_W*WORDS-1:0]   a;
  logic [CMP_WORD_W*WORDS-1:0]   b;
  logic                          out_valid;
  logic                          out_ready;
  logic                          great;
  logic                          equal;
  logic                          less;
  logic [CW-1:0]                 words_used;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, great, equal, less, words_used
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, great, equal, less, words_used
  );

endinterface

// File: rtl/cmp_word_seq_word.sv
// Combinational 16-bit magnitude compare with cascade inputs; the cascade
// values pass through only when the two words are equal.
module cmp_word_seq_word
  import cmp_word_seq_pkg::*;
(
  input  logic [CMP_WORD_W-1:0] a,
  input  logic [CMP_WORD_W-1:0] b,
  input  logic                  greatin,
  input  logic                  equalin,
  input  logic                  lessin,
  output logic                  great,
  output logic                  equal,
  output logic                  less
);

  // Word magnitude decision, deferring to the cascade on a tie
  always_comb begin
    great = 1'b0;
    equal = 1'b0;
    less  = 1'b0;
    if (a > b) begin
      great = 1'b1;
    end else if (a < b) begin
      less = 1'b1;
    end else begin
      great = greatin;
      equal = equalin;
      less  = lessin;
    end
  end

endmodule

// File: rtl/cmp_word_seq.sv
// Sequential WORDS x 16-bit magnitude comparator, MSW first, one word per clock.
// Define CMP_SIGNED_EN to treat the operands as two's complement.
module cmp_word_seq
  import cmp_word_seq_pkg::*;
#(
  parameter int WORDS = 4
)(
  input  logic             clk,
  input  logic             rst,
  cmp_word_seq_if.slave    bus,
  output logic             busy
);

  localparam int CW = $clog2(WORDS + 1);
  localparam int IW = $clog2(WORDS);
  localparam int OW = CMP_WORD_W * WORDS;
  localparam logic [IW-1:0] IDX_MSW  = IW'(WORDS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [CW-1:0] WORDS_CW = CW'(WORDS);

  cmp_state_e            state_r;
  logic [OW-1:0]         a_r;
  logic [OW-1:0]         b_r;
  logic [IW-1:0]         idx_r;
  logic [2:0]            res_r;
  logic [2:0]            flags_r;
  logic [CW-1:0]         used_r;
  logic [CW-1:0]         words_used_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  busy_r;

  logic [CMP_WORD_W-1:0] a_words_s [WORDS];
  logic [CMP_WORD_W-1:0] b_words_s [WORDS];
  logic [CMP_WORD_W-1:0] a_word_s;
  logic [CMP_WORD_W-1:0] b_word_s;
  logic                  cmp_gt_s;
  logic                  cmp_eq_s;
  logic                  cmp_lt_s;
  logic                  sign_split_s;
  logic                  dec_done_s;
  logic [2:0]            dec_res_s;

  for (genvar i = 0; i < WORDS; i++) begin : g_words
    assign a_words_s[i] = a_r[CMP_WORD_W*i +: CMP_WORD_W];
    assign b_words_s[i] = b_r[CMP_WORD_W*i +: CMP_WORD_W];
  end

  assign a_word_s = a_words_s[idx_r];
  assign b_word_s = b_words_s[idx_r];

  cmp_word_seq_word u_word (
    .a       (a_word_s),
    .b       (b_word_s),
    .greatin (1'b0),
    .equalin (1'b1),
    .lessin  (1'b0),
    .great   (cmp_gt_s),
    .equal   (cmp_eq_s),
    .less    (cmp_lt_s)
  );

`ifdef CMP_SIGNED_EN
  // Differing sign bits settle the whole compare on the MSW alone
  assign sign_split_s = (idx_r == IDX_MSW) && (a_r[OW-1] != b_r[OW-1]);
`else
  assign sign_split_s = 1'b0;
`endif

  // Decide on the current word: stop on a difference or on the last word
  always_comb begin
    dec_done_s = 1'b0;
    dec_res_s  = CMP_RES_NONE;
    if (sign_split_s) begin
      dec_done_s = 1'b1;
      dec_res_s  = a_r[OW-1] ? CMP_RES_LESS : CMP_RES_GREAT;
    end else if (!cmp_eq_s || (idx_r == {IW{1'b0}})) begin
      dec_done_s = 1'b1;
      dec_res_s  = cmp_res_f(cmp_gt_s, cmp_lt_s);
    end else begin
      dec_done_s = 1'b0;
      dec_res_s  = CMP_RES_NONE;
    end
  end

  // Control FSM; the decision is staged in res_r/used_r and published one clock later
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= CMP_S_IDLE;
      a_r          <= {OW{1'b0}};
      b_r          <= {OW{1'b0}};
      idx_r        <= {IW{1'b0}};
      res_r        <= CMP_RES_NONE;
      used_r       <= {CW{1'b0}};
      flags_r      <= CMP_RES_NONE;
      words_used_r <= {CW{1'b0}};
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        CMP_S_IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            idx_r      <= IDX_MSW;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= CMP_S_CMP;
          end
        end
        CMP_S_CMP: begin
          if (dec_done_s) begin
            res_r   <= dec_res_s;
            used_r  <= WORDS_CW - CW'(idx_r);
            state_r <= CMP_S_DONE;
          end else begin
            idx_r <= idx_r - IDX_ONE;
          end
        end
        CMP_S_DONE: begin
          if (!out_valid_r) begin
            out_valid_r  <= 1'b1;
            flags_r      <= res_r;
            words_used_r <= used_r;
          end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
            flags_r      <= CMP_RES_NONE;
            words_used_r <= {CW{1'b0}};
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= CMP_S_IDLE;
          end
        end
        default: begin
          state_r      <= CMP_S_IDLE;
          flags_r      <= CMP_RES_NONE;
          words_used_r <= {CW{1'b0}};
          in_ready_r   <= 1'b1;
          out_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready                      = in_ready_r & ~rst;
  assign bus.out_valid                     = out_valid_r;
  assign {bus.great, bus.equal, bus.less}  = flags_r;
  assign bus.words_used                    = words_used_r;
  assign busy                              = busy_r;

endmodule

// File: tb/tb_cmp_word_seq.sv
// Scoreboard bench for cmp_word_seq (WORDS=4); expectations come from a
// full-width reference compare, honouring CMP_SIGNED_EN when it is defined.
module tb_cmp_word_seq;

  typedef struct {
    logic [2:0] res;
    int         used;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  cmp_word_seq_if #(.WORDS(4)) bus ();

  cmp_word_seq #(.WORDS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full-width compare; words_used follows the highest differing bit
  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv);
    exp_t       e;
    logic [63:0] d;
    d      = av ^ bv;
    e.used = 4;
    for (int i = 0; i < 64; i++) begin
      if (d[i]) e.used = 4 - i / 16;
    end
`ifdef CMP_SIGNED_EN
    if ($signed(av) > $signed(bv))      e.res = 3'b100;
    else if ($signed(av) < $signed(bv)) e.res = 3'b001;
    else                                e.res = 3'b010;
`else
    if (av > bv)      e.res = 3'b100;
    else if (av < bv) e.res = 3'b001;
    else              e.res = 3'b010;
`endif
    return e;
  endfunction

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
  endtask

  task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input int hold);
    exp_t e;
    int   j;
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = (hold == 0);
    sb.push_back(model(av, bv));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = bv ^ 64'h5A5A_A5A5_5A5A_A5A5;
    j = 0;
    @(negedge clk);
    while (!bus.out_valid && j < 40) begin
      chk("in_ready_busy", {bus.in_ready, busy}, 2'b01);
      chk("flags_idle", {bus.great, bus.equal, bus.less}, 3'b000);
      @(negedge clk);
      j++;
    end
    e = sb.pop_front();
    chk("latency", j, e.used + 1);
    if (bus.out_valid) begin
      chk("result", {bus.great, bus.equal, bus.less}, e.res);
      chk("words_used", bus.words_used, e.used);
      chk("in_ready_done", bus.in_ready, 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_state", {bus.out_valid, bus.in_ready, busy}, 3'b101);
        chk("hold_result", {bus.great, bus.equal, bus.less}, e.res);
        chk("hold_used", bus.words_used, e.used);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post_hs", {bus.out_valid, bus.in_ready, busy}, 3'b010);
      chk("post_hs_flags", {bus.great, bus.equal, bus.less}, 3'b000);
    end
  endtask

  initial begin
    logic [63:0] av;
    logic [63:0] bv;
    exp_t        e;
    int          guard;
    int          n_acc;
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 64'h0;
    bus.b         = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_flags", {bus.great, bus.equal, bus.less}, 3'b000);
    chk("rst_used", bus.words_used, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);
    @(negedge clk);

    run_op(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);
    run_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0006, 10);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 0);

    // Reset during the second CMP cycle of an equal compare
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.a         = 64'hCAFE_F00D_CAFE_F00D;
    bus.b         = 64'hCAFE_F00D_CAFE_F00D;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {bus.out_valid, busy}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", {bus.out_valid, busy, bus.in_ready}, 3'b000);
    chk("mid_rst_flags", {bus.great, bus.equal, bus.less}, 3'b000);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("mid_no_result", bus.out_valid, 0);
    run_op(64'h1, 64'h0, 0);

    // Back-to-back: in_valid held high, operands change every cycle
    bus.out_ready = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_result", {bus.great, bus.equal, bus.less}, e.res);
          chk("b2b_used", bus.words_used, e.used);
        end else begin
          chk("b2b_spurious", bus.out_valid, 0);
        end
      end
      av = {$urandom, $urandom};
      bv = av;
      for (int w = 0; w < 4; w++) begin
        if ($urandom_range(0, 2) == 0) bv[16*w +: 16] = 16'($urandom);
      end
      bus.in_valid = 1'b1;
      bus.a        = av;
      bus.b        = bv;
      if (bus.in_ready) begin
        sb.push_back(model(av, bv));
        n_acc++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 40) begin
      if (bus.out_valid) begin
        e = sb.pop_front();
        chk("b2b_result", {bus.great, bus.equal, bus.less}, e.res);
        chk("b2b_used", bus.words_used, e.used);
      end
      @(negedge clk);
      guard++;
    end
    chk("b2b_drained", sb.size(), 0);
    chk("b2b_accepts", (n_acc >= 20), 1);

    for (int r = 0; r < 6; r++) begin
      av = {$urandom, $urandom};
      bv = av;
      bv[16*$urandom_range(0, 3) +: 16] = 16'($urandom);
      run_op(av, bv, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
